// File: rtl/osl_hostbuf.sv
// osl_hostbuf: host-side TX/RX FIFO buffering in front of the serial link transceiver.
// Ports:
//   i_clk, i_resetb           : clock and asynchronous active-low reset
//   i_cpu_wr/i_cpu_din        : host push into the TX FIFO
//   i_cpu_rd/o_cpu_dout       : host pop from the RX FIFO (first-word-fall-through head)
//   o_cpu_txfull/o_cpu_rxempty: FIFO status
//   o_tx_level/o_rx_level     : fill levels
//   o_err_ovf/o_err_unf       : sticky error flags
//   i_cpu_clr_err             : clears the sticky flags
//   o_link_wr/o_link_din/i_link_dir              : transceiver write port
//   o_link_rd/i_link_dout/i_link_dor             : transceiver read port
module osl_hostbuf #(
    parameter int WORDSZ     = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  i_clk,
    input  logic                  i_resetb,
    input  logic                  i_cpu_wr,
    input  logic [WORDSZ-1:0]     i_cpu_din,
    input  logic                  i_cpu_rd,
    output logic [WORDSZ-1:0]     o_cpu_dout,
    output logic                  o_cpu_txfull,
    output logic                  o_cpu_rxempty,
    output logic [DEPTH_LOG2:0]   o_tx_level,
    output logic [DEPTH_LOG2:0]   o_rx_level,
    output logic                  o_err_ovf,
    output logic                  o_err_unf,
    input  logic                  i_cpu_clr_err,
    output logic                  o_link_wr,
    output logic [WORDSZ-1:0]     o_link_din,
    input  logic                  i_link_dir,
    output logic                  o_link_rd,
    input  logic [WORDSZ-1:0]     i_link_dout,
    input  logic                  i_link_dor
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] L_FULL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {T_IDLE, T_PULSE, T_HOLD} tx_st_t;
    typedef enum logic [1:0] {R_IDLE, R_PULSE, R_HOLD} rx_st_t;

    logic [WORDSZ-1:0]     r_tx_mem [DEPTH];
    logic [WORDSZ-1:0]     r_rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [DEPTH_LOG2:0]   r_tx_lvl, r_rx_lvl;
    logic                  r_ovf, r_unf;
    logic [WORDSZ-1:0]     r_link_din;
    tx_st_t                r_tx_st, w_tx_nxt;
    rx_st_t                r_rx_st, w_rx_nxt;

    logic w_tx_full, w_rx_full, w_tx_empty, w_rx_empty;
    logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic w_ovf_ev, w_unf_ev;
    logic w_link_wr, w_link_rd;

    assign w_tx_full  = (r_tx_lvl == L_FULL);
    assign w_rx_full  = (r_rx_lvl == L_FULL);
    assign w_tx_empty = (r_tx_lvl == '0);
    assign w_rx_empty = (r_rx_lvl == '0);

    // Full/empty checks use the current level, so a same-cycle pop does not
    // make room for a push on a full FIFO.
    assign w_tx_push = i_cpu_wr & ~w_tx_full;
    assign w_rx_pop  = i_cpu_rd & ~w_rx_empty;
    assign w_ovf_ev  = i_cpu_wr & w_tx_full;
    assign w_unf_ev  = i_cpu_rd & w_rx_empty;

    // ---------------- TX FSM ----------------
    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) r_tx_st <= T_IDLE;
        else           r_tx_st <= w_tx_nxt;
    end

    always_comb begin
        w_tx_nxt = r_tx_st;
        unique case (r_tx_st)
            T_IDLE:  if (!w_tx_empty && i_link_dir) w_tx_nxt = T_PULSE;
            T_PULSE: w_tx_nxt = T_HOLD;
            T_HOLD:  w_tx_nxt = T_IDLE;
            default: w_tx_nxt = T_IDLE;
        endcase
    end

    always_comb begin
        w_tx_pop  = (r_tx_st == T_IDLE) && !w_tx_empty && i_link_dir;
        w_link_wr = (r_tx_st == T_PULSE);
    end

    // ---------------- RX FSM ----------------
    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) r_rx_st <= R_IDLE;
        else           r_rx_st <= w_rx_nxt;
    end

    always_comb begin
        w_rx_nxt = r_rx_st;
        unique case (r_rx_st)
            R_IDLE:  if (i_link_dor && !w_rx_full) w_rx_nxt = R_PULSE;
            R_PULSE: w_rx_nxt = R_HOLD;
            R_HOLD:  w_rx_nxt = R_IDLE;
            default: w_rx_nxt = R_IDLE;
        endcase
    end

    // A full RX FIFO withholds the read strobe, leaving the word in the transceiver.
    always_comb begin
        w_rx_push = (r_rx_st == R_IDLE) && i_link_dor && !w_rx_full;
        w_link_rd = (r_rx_st == R_PULSE);
    end

    // ---------------- storage ----------------
    always_ff @(posedge i_clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= i_cpu_din;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= i_link_dout;
    end

    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) begin
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_tx_lvl   <= '0;
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_rx_lvl   <= '0;
            r_link_din <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop) begin
                r_tx_rp    <= r_tx_rp + 1'b1;
                r_link_din <= r_tx_mem[r_tx_rp];
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_lvl <= r_tx_lvl + 1'b1;
                2'b01:   r_tx_lvl <= r_tx_lvl - 1'b1;
                default: r_tx_lvl <= r_tx_lvl;
            endcase
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_lvl <= r_rx_lvl + 1'b1;
                2'b01:   r_rx_lvl <= r_rx_lvl - 1'b1;
                default: r_rx_lvl <= r_rx_lvl;
            endcase
        end
    end

    // Error event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= (r_ovf & ~i_cpu_clr_err) | w_ovf_ev;
            r_unf <= (r_unf & ~i_cpu_clr_err) | w_unf_ev;
        end
    end

    assign o_cpu_dout    = w_rx_empty ? '0 : r_rx_mem[r_rx_rp];
    assign o_cpu_txfull  = w_tx_full;
    assign o_cpu_rxempty = w_rx_empty;
    assign o_tx_level    = r_tx_lvl;
    assign o_rx_level    = r_rx_lvl;
    assign o_err_ovf     = r_ovf;
    assign o_err_unf     = r_unf;
    assign o_link_wr     = w_link_wr;
    assign o_link_rd     = w_link_rd;
    assign o_link_din    = r_link_din;

endmodule

// File: tb/tb_osl_hostbuf.sv
// tb_osl_hostbuf: directed self-checking bench for osl_hostbuf.
// Drives host and transceiver sides and checks against hand-computed values.
module tb_osl_hostbuf;

    logic       clk, resetb;
    logic       cpu_wr, cpu_rd, cpu_clr_err;
    logic [7:0] cpu_din, cpu_dout;
    logic       cpu_txfull, cpu_rxempty;
    logic [3:0] tx_level, rx_level;
    logic       err_ovf, err_unf;
    logic       link_wr, link_rd, link_dir, link_dor;
    logic [7:0] link_din, link_dout;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    osl_hostbuf #(.WORDSZ(8), .DEPTH_LOG2(3)) dut (
        .i_clk(clk), .i_resetb(resetb),
        .i_cpu_wr(cpu_wr), .i_cpu_din(cpu_din),
        .i_cpu_rd(cpu_rd), .o_cpu_dout(cpu_dout),
        .o_cpu_txfull(cpu_txfull), .o_cpu_rxempty(cpu_rxempty),
        .o_tx_level(tx_level), .o_rx_level(rx_level),
        .o_err_ovf(err_ovf), .o_err_unf(err_unf),
        .i_cpu_clr_err(cpu_clr_err),
        .o_link_wr(link_wr), .o_link_din(link_din), .i_link_dir(link_dir),
        .o_link_rd(link_rd), .i_link_dout(link_dout), .i_link_dor(link_dor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] txq[$];
    logic [7:0] exp_w, rx_exp;
    int k, npulse, maxlvl;

    initial begin
        resetb = 1'b0; cpu_wr = 0; cpu_rd = 0; cpu_clr_err = 0; cpu_din = '0;
        link_dir = 0; link_dor = 0; link_dout = '0;
        tick(); tick();
        chk("rst_link_wr", link_wr, 0);
        chk("rst_link_rd", link_rd, 0);
        chk("rst_link_din", link_din, 8'h00);
        chk("rst_txfull", cpu_txfull, 0);
        chk("rst_rxempty", cpu_rxempty, 1);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_ovf", err_ovf, 0);
        chk("rst_unf", err_unf, 0);
        chk("rst_dout", cpu_dout, 8'h00);
        resetb = 1'b1;
        tick();

        // Two words, dir high: pulses three cycles apart
        link_dir = 1;
        cpu_wr = 1; cpu_din = 8'hA5; tick();
        chk("tx_lvl_1", tx_level, 1);
        cpu_din = 8'h3C; tick();
        cpu_wr = 0;
        chk("tx_p1_wr", link_wr, 1);
        chk("tx_p1_din", link_din, 8'hA5);
        tick();
        chk("tx_hold_wr", link_wr, 0);
        tick();
        chk("tx_idle_wr", link_wr, 0);
        tick();
        chk("tx_p2_wr", link_wr, 1);
        chk("tx_p2_din", link_din, 8'h3C);
        chk("tx_p2_lvl", tx_level, 0);
        tick();
        chk("tx_p2_end", link_wr, 0);
        tick(); tick();

        // Overflow with dir low
        link_dir = 0;
        for (int i = 0; i < 9; i++) begin
            cpu_wr = 1; cpu_din = 8'h40 + 8'(i); tick();
        end
        cpu_wr = 0;
        chk("ovf_full", cpu_txfull, 1);
        chk("ovf_lvl", tx_level, 8);
        chk("ovf_flag", err_ovf, 1);
        chk("ovf_no_wr", link_wr, 0);
        link_dir = 1;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (link_wr) begin
                exp_w = 8'h40 + 8'(k);
                chk("ovf_drain_din", link_din, exp_w);
                k++;
            end
        end
        chk("ovf_drain_cnt", k, 8);
        chk("ovf_drain_lvl", tx_level, 0);
        chk("ovf_sticky", err_ovf, 1);
        cpu_clr_err = 1; tick(); cpu_clr_err = 0;
        chk("ovf_clr", err_ovf, 0);

        // RX fill with no host reads
        link_dor = 1; link_dout = 8'h10; npulse = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (link_rd) begin
                npulse++;
                link_dout = link_dout + 8'h01;
            end
        end
        chk("rx_rd_cnt", npulse, 8);
        chk("rx_lvl_full", rx_level, 8);
        chk("rx_not_empty", cpu_rxempty, 0);
        chk("rx_no_rd", link_rd, 0);
        npulse = 0; rx_exp = 8'h10;
        for (int i = 0; i < 8; i++) begin
            chk("rx_pop_data", cpu_dout, rx_exp);
            rx_exp = rx_exp + 8'h01;
            cpu_rd = 1; tick();
            if (link_rd) begin
                npulse++;
                link_dout = link_dout + 8'h01;
            end
        end
        cpu_rd = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (link_rd) begin
                npulse++;
                link_dout = link_dout + 8'h01;
            end
        end
        chk("rx_rd_resume", (npulse > 0), 1);
        link_dor = 0;
        tick();
        if (link_rd) link_dout = link_dout + 8'h01;
        for (int c = 0; c < 20 && !cpu_rxempty; c++) begin
            chk("rx_drain_data", cpu_dout, rx_exp);
            rx_exp = rx_exp + 8'h01;
            cpu_rd = 1; tick();
        end
        cpu_rd = 0;
        chk("rx_drain_seq", rx_exp, link_dout);
        chk("rx_drain_lvl", rx_level, 0);

        // Underflow
        tick(); tick(); tick();
        cpu_rd = 1; tick(); cpu_rd = 0;
        chk("unf_flag", err_unf, 1);
        chk("unf_lvl", rx_level, 0);
        chk("unf_dout", cpu_dout, 8'h00);
        cpu_rd = 1; cpu_clr_err = 1; tick();
        chk("unf_clr_lose", err_unf, 1);
        cpu_rd = 0; tick();
        cpu_clr_err = 0;
        chk("unf_clr", err_unf, 0);

        // Full duplex with scoreboard
        link_dir = 1; link_dor = 1; link_dout = 8'h80;
        rx_exp = 8'h80; exp_w = 8'hC0; maxlvl = 0;
        for (int c = 0; c < 120; c++) begin
            if (link_wr) chk("fd_tx_data", link_din, txq.size() > 0 ? txq.pop_front() : 8'hxx);
            if (link_rd) link_dout = link_dout + 8'h01;
            if (c == 80) link_dor = 0;
            if (int'(tx_level) > maxlvl) maxlvl = int'(tx_level);
            if (int'(rx_level) > maxlvl) maxlvl = int'(rx_level);
            cpu_wr = (c < 60) && !cpu_txfull;
            cpu_din = exp_w;
            if (cpu_wr) begin
                txq.push_back(exp_w);
                exp_w = exp_w + 8'h01;
            end
            cpu_rd = !cpu_rxempty;
            if (cpu_rd) begin
                chk("fd_rx_data", cpu_dout, rx_exp);
                rx_exp = rx_exp + 8'h01;
            end
            tick();
        end
        cpu_wr = 0; cpu_rd = 0;
        chk("fd_txq_empty", txq.size(), 0);
        chk("fd_tx_lvl", tx_level, 0);
        chk("fd_rx_lvl", rx_level, 0);
        chk("fd_rx_seq", rx_exp, link_dout);
        chk("fd_max_lvl", (maxlvl <= 8), 1);
        chk("fd_no_ovf", err_ovf, 0);
        chk("fd_no_unf", err_unf, 0);

        // Reset in the middle of a TX pulse
        link_dor = 1; link_dout = 8'h55;
        cpu_wr = 1; cpu_din = 8'h99;
        tick();
        link_dor = 0; cpu_wr = 0;
        tick();
        chk("mid_pre_wr", link_wr, 1);
        chk("mid_pre_rx", cpu_rxempty, 0);
        #2 resetb = 1'b0;
        #1;
        chk("mid_link_wr", link_wr, 0);
        chk("mid_tx_lvl", tx_level, 0);
        chk("mid_rxempty", cpu_rxempty, 1);
        chk("mid_link_din", link_din, 8'h00);
        tick();
        resetb = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
